// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters,
// with a per-transaction lock so one requester can hold the RAM across a read-modify-write.
module ram_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 15,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   resp_valid,
  output logic [DW-1:0]     resp_rdata,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_data_in,
  input  logic [DW-1:0]     ram_data_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PW-1:0] idx_t;

  idx_t            ptr_q, ptr_d;
  idx_t            owner_q, owner_d;
  logic            locked_q, locked_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;

  logic            grant_vld;
  idx_t            grant_idx;

  function automatic idx_t wrap_add(input idx_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return idx_t'(s);
  endfunction

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!rst) begin
      if (locked_q) begin
        if (req_valid[owner_q]) begin
          grant_vld = 1'b1;
          grant_idx = owner_q;
        end
      end else begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req_valid[wrap_add(ptr_q, k)]) begin
            grant_vld = 1'b1;
            grant_idx = wrap_add(ptr_q, k);
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_idx == idx_t'(i))) begin
        ram_we      = req_we[i];
        ram_addr    = req_addr[i*AW +: AW];
        ram_data_in = req_wdata[i*DW +: DW];
      end
    end
  end

  // While locked the pointer is frozen so fairness resumes where it left off.
  always_comb begin
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    locked_d     = locked_q;
    resp_valid_d = '0;
    if (grant_vld) begin
      resp_valid_d[grant_idx] = 1'b1;
      if (!locked_q) ptr_d = wrap_add(grant_idx, 1);
      if (req_lock[grant_idx]) begin
        locked_d = 1'b1;
        owner_d  = grant_idx;
      end else begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      locked_q     <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      locked_q     <= locked_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  // The RAM reads before it writes, so a write's response carries the old contents.
  assign resp_rdata = ram_data_out;

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_ready_has_valid : assert property (@(posedge clk) disable iff (rst) (req_ready & ~req_valid) == '0);
  a_resp_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid));

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous `ram` between NREQ requesters, for example the core's fetch, load and store ports.
- Each requester uses a valid/ready request handshake; the arbiter returns a one-cycle-latency response pulse.
- Arbitration is round-robin. A lock lets one requester hold the RAM across a 6502 read-modify-write sequence.
- Sits directly in front of the `ram` instance and drives all of its ports except `clk`.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 15, address width; matches the `ram` address parameter.
- DW, 8, data width; matches the `ram` data parameter.

Ports:
- clk  input  1  single clock, rising-edge; also feeds the `ram` clock.
- rst  input  1  reset, asynchronous and active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; a request is accepted when req_valid[i] & req_ready[i] at a rising edge.
- req_we  input  NREQ  per-requester write enable (1 = write, 0 = read).
- req_lock  input  NREQ  keep ownership after this transaction.
- req_addr  input  NREQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_wdata  input  NREQ*DW  flattened write data; requester i occupies bits [i*DW +: DW].
- resp_valid  output  NREQ  one-cycle pulse, one cycle after acceptance.
- resp_rdata  output  DW  shared response data; meaningful only while some resp_valid bit is high.
- ram_we  output  1  to `ram` we.
- ram_addr  output  AW  to `ram` addr.
- ram_data_in  output  DW  to `ram` data_in.
- ram_data_out  input  DW  from `ram` data_out.

Behaviour:
- State registers:
  - ptr: round-robin priority pointer, 0..NREQ-1.
  - locked: 1 bit.
  - owner: index of the locking requester.
  - resp_valid: NREQ bits.
- Reset (asynchronous, while rst=1):
  - ptr=0, locked=0, owner=0, resp_valid=0.
  - req_ready=0, ram_we=0, ram_addr=0, ram_data_in=0.
- Grant selection (combinational, same cycle):
  - Unlocked: grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - Locked: grant only owner, and only if req_valid[owner]=1. All others see req_ready=0.
  - At most one req_ready bit is high. req_ready[i] never rises without req_valid[i].
- RAM drive:
  - With a grant g: ram_addr=req_addr[g], ram_data_in=req_wdata[g], ram_we=req_we[g].
  - With no grant: ram_we=0, ram_addr=0, ram_data_in=0.
- On an accepted transaction from requester g at a rising edge:
  - resp_valid <= one-hot(g), so the pulse is exactly 1 cycle wide in the next cycle.
  - Unlocked: ptr <= (g+1) mod NREQ.
  - Locked: ptr is unchanged.
  - If req_lock[g]=1: locked <= 1, owner <= g.
  - If req_lock[g]=0: locked <= 0.
- On a cycle with no accepted transaction: resp_valid <= 0; ptr, locked and owner hold.
- resp_rdata = ram_data_out, combinational passthrough.
  - Read: data at the accepted address.
  - Write: the OLD contents of the written address, because `ram` reads before it writes. This gives an RMW old-value fetch for free.
- Back-to-back requests:
  - A requester may be accepted every cycle.
  - A response for cycle N's acceptance coexists with cycle N+1's RAM access.
  - A write in N+1 must not disturb the resp_rdata of a read in N, since `ram` keeps data_out stable under a following write.
- Lock held while the owner is idle: no grants are issued, the RAM stays idle and other requesters starve. The lock is released only by the owner's next transaction with req_lock=0.
- Reset mid-lock or mid-response: locked, owner and any pending resp_valid clear immediately (asynchronously). No response is issued after reset.
- NREQ=1 degenerates to a pass-through with the one-cycle resp_valid.

Test Plan:
1. Reset: hold rst=1 with all req_valid=1 -> req_ready=0, ram_we=0 and resp_valid=0 throughout. Deassert rst -> requester 0 is granted first (ptr=0).
2. Read after write: req0 writes 8'h56 to 15'h1234, then req0 reads 15'h1234 -> resp_valid=2'b01 the cycle after each acceptance; the read response returns resp_rdata=8'h56.
3. Round-robin: both requesters valid continuously, reading 15'h0001 and 15'h0002 -> grants alternate 0,1,0,1. resp_valid alternates 01,10, and each resp_rdata matches the preloaded data for that requester's address.
4. Lock: req1 reads 15'h5678 with lock=1 (contents 8'h9a) while req0 stays valid. Then req1 writes 8'h03 to 15'h5678 with lock=0 ->
   - req0 gets no ready during those 2 cycles.
   - The write's resp_rdata is 8'h9a.
   - req0 is granted in the next cycle.
   - A later read of 15'h5678 returns 8'h03.
5. Idle owner: req0 is accepted with lock=1, then drops valid for 3 cycles while req1 is valid -> req_ready=0 and ram_we=0 for all 3 cycles. When req0 issues a transaction with lock=0, it is accepted and the lock releases.
6. Async reset mid-lock: assert rst between clock edges while locked with a resp_valid pending -> resp_valid clears and locked clears without waiting for a clock edge. After release, arbitration restarts at ptr=0.
